alu_issue_sched: RTL and testbench
==================================

# alu_issue_sched

Issue scheduler in front of the ALU control decoder. It arbitrates between two uop requesters, the main decode pipe (req0) and the address/branch pipe (req1), for the single shared ALU. Each cycle it registers at most one R/I-type uop onto the ALU control inputs. It tracks in-flight uops through a fixed-latency shadow pipeline so that writeback is signalled with the correct destination tag and source.

## Interface
Parameters:
- TAG_W, 5, destination register tag width
- LAT, 2, cycles from `iss_valid` to result at ALU output; legal 1..4
- CNT_W, 16, width of the saturating issue counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- req0_valid / req1_valid  in  1  requester holds a uop
- req0_ready / req1_ready  out  1  combinational grant; uop consumed at the edge where valid&&ready
- reqN_opcode  in  7  instruction type field, per requester
- reqN_funct3  in  3  funct3, per requester
- reqN_funct7  in  7  funct7, per requester
- reqN_rd  in  TAG_W  destination tag, per requester
- alu_stall  in  1  ALU cannot take a new uop this cycle
- iss_valid  out  1  registered; uop presented to ALU control this cycle
- iss_opcode / iss_funct3 / iss_funct7  out  7/3/7  registered uop fields; drive ALU control `instruction_type`/`funct3`/`funct7`
- iss_rd  out  TAG_W  registered tag of issued uop
- iss_src  out  1  0 = req0, 1 = req1
- wb_valid  out  1  result with nonzero rd available this cycle
- wb_rd  out  TAG_W  tag of that result
- wb_src  out  1  requester of that result
- ill_op  out  1  one-cycle pulse: an unsupported opcode was consumed
- busy  out  1  any uop in iss stage or shadow pipeline
- issue_cnt  out  CNT_W  saturating count of issued uops

## Operation
- Supported opcodes: R_TYPE_OP (7'b0110011), I_TYPE_OP (7'b0010011). Other opcodes are consumed like a normal grant, never issued, and pulse ill_op the next cycle.
- Candidate = reqN_valid. A grant occurs only when alu_stall = 0.
- Round-robin pointer rr (reset 0):
  - Both valid: req[rr] is granted.
  - Exactly one valid: that requester is granted regardless of rr.
  - After any grant (including an illegal one), rr is set to the other requester's index.
  - If no grant occurs, rr holds.
- reqN_ready = grant_N. At most one ready is high per cycle. Ready never asserts while alu_stall = 1.
- Issue register: on a legal grant, load fields with iss_valid = 1. Otherwise iss_valid = 0 and the fields hold their previous values.
- Shadow pipeline:
  - LAT stages of {v, rd, src}. Stage 0 loads from the issue register; every stage shifts every cycle, regardless of alu_stall.
  - At the last stage, wb_valid = v && (rd != 0). rd = 0 results are silently retired.
- busy = iss_valid | OR of all shadow v bits.
- issue_cnt increments by 1 for each cycle with iss_valid = 1 and saturates at all-ones.
- Reset (reset = 0 at an edge) clears all of the following, and reset has priority over any grant that cycle:
  - iss_*, shadow stages, rr, ill_op, issue_cnt
- Reset mid-operation: in-flight results are discarded, and wb_valid is 0 from the cycle after the reset edge.

## Timing
- Grant at edge N produces iss_valid high during cycle N+1. wb_valid for that uop is high during cycle N+1+LAT.
- Back-to-back issue is allowed: one uop per cycle, with maximum throughput of 1/cycle.
- With both requesters continuously valid and no stall, grants alternate req0, req1, req0, … A requester therefore waits at most 1 cycle.
- alu_stall acts combinationally on ready in the same cycle. A uop already in iss stage is not held or replayed; stall only blocks new grants.
- Reset values: all outputs 0. req ready is 0 while reset = 0.

## Test plan
- Reset: hold reset = 0 for 3 cycles with both requesters valid. Required: no ready, all outputs 0. Release reset: req0 is granted first (rr = 0).
- Contention: both valid for 6 cycles, LAT = 2, rd = 1..6. Required:
  - iss_src sequence 0,1,0,1,0,1
  - wb_rd sequence 1..6, each 3 cycles after its grant edge
  - issue_cnt = 6
- Stall: alu_stall = 1 for 3 cycles with both valid. Required: no ready, iss_valid = 0, rr unchanged, shadow pipeline keeps draining. After release, rr resumes from its pre-stall value.
- Illegal op: req1 presents opcode 7'b1100011. Required: req1_ready high, ill_op pulses 1 cycle later, no iss_valid, no wb_valid, rr toggles.
- rd = 0 and saturation: issue ADD with rd = 0. Required: iss_valid = 1 but no wb_valid. Force issue_cnt near max with CNT_W = 4 and issue 20 uops: required issue_cnt = 15.
- Mid-flight reset: issue 2 uops, then assert reset the cycle after the second. Required: wb_valid never asserts and busy = 0 after the reset edge.

Source files
------------

// File: rtl/alu_issue_sched.sv
// Issue scheduler for the shared ALU: round-robin arbitration between two uop requesters,
// a registered issue stage and a fixed-latency shadow pipeline that signals writeback.
module alu_issue_sched #(
    parameter int unsigned TAG_W = 5,
    parameter int unsigned LAT   = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [6:0]       req0_opcode,
    input  logic [2:0]       req0_funct3,
    input  logic [6:0]       req0_funct7,
    input  logic [TAG_W-1:0] req0_rd,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [6:0]       req1_opcode,
    input  logic [2:0]       req1_funct3,
    input  logic [6:0]       req1_funct7,
    input  logic [TAG_W-1:0] req1_rd,
    input  logic             alu_stall,
    output logic             iss_valid,
    output logic [6:0]       iss_opcode,
    output logic [2:0]       iss_funct3,
    output logic [6:0]       iss_funct7,
    output logic [TAG_W-1:0] iss_rd,
    output logic             iss_src,
    output logic             wb_valid,
    output logic [TAG_W-1:0] wb_rd,
    output logic             wb_src,
    output logic             ill_op,
    output logic             busy,
    output logic [CNT_W-1:0] issue_cnt
);

    localparam logic [6:0] R_TYPE_OP = 7'b0110011;
    localparam logic [6:0] I_TYPE_OP = 7'b0010011;

    logic             rr_q;
    logic             grant0;
    logic             grant1;
    logic             any_grant;
    logic             sel_legal;
    logic [6:0]       sel_opcode;
    logic [2:0]       sel_funct3;
    logic [6:0]       sel_funct7;
    logic [TAG_W-1:0] sel_rd;

    logic             sh_v_q   [LAT];
    logic [TAG_W-1:0] sh_rd_q  [LAT];
    logic             sh_src_q [LAT];

    // Grants are suppressed while reset is held so no uop is consumed and then dropped.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset && !alu_stall) begin
            if (req0_valid && req1_valid) begin
                if (rr_q) begin
                    grant1 = 1'b1;
                end else begin
                    grant0 = 1'b1;
                end
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign any_grant  = grant0 | grant1;

    always_comb begin
        sel_opcode = grant1 ? req1_opcode : req0_opcode;
        sel_funct3 = grant1 ? req1_funct3 : req0_funct3;
        sel_funct7 = grant1 ? req1_funct7 : req0_funct7;
        sel_rd     = grant1 ? req1_rd     : req0_rd;
        sel_legal  = (sel_opcode == R_TYPE_OP) || (sel_opcode == I_TYPE_OP);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_q       <= 1'b0;
            iss_valid  <= 1'b0;
            iss_opcode <= '0;
            iss_funct3 <= '0;
            iss_funct7 <= '0;
            iss_rd     <= '0;
            iss_src    <= 1'b0;
            ill_op     <= 1'b0;
            issue_cnt  <= '0;
            for (int i = 0; i < LAT; i++) begin
                sh_v_q[i]   <= 1'b0;
                sh_rd_q[i]  <= '0;
                sh_src_q[i] <= 1'b0;
            end
        end else begin
            iss_valid <= any_grant && sel_legal;
            ill_op    <= any_grant && !sel_legal;
            if (any_grant && sel_legal) begin
                iss_opcode <= sel_opcode;
                iss_funct3 <= sel_funct3;
                iss_funct7 <= sel_funct7;
                iss_rd     <= sel_rd;
                iss_src    <= grant1;
            end
            // Pointer moves to the requester that was not just served.
            if (any_grant) begin
                rr_q <= grant0;
            end
            if (iss_valid && (issue_cnt != '1)) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
            sh_v_q[0]   <= iss_valid;
            sh_rd_q[0]  <= iss_rd;
            sh_src_q[0] <= iss_src;
            for (int i = 1; i < LAT; i++) begin
                sh_v_q[i]   <= sh_v_q[i-1];
                sh_rd_q[i]  <= sh_rd_q[i-1];
                sh_src_q[i] <= sh_src_q[i-1];
            end
        end
    end

    // Results targeting tag 0 retire without a writeback strobe.
    assign wb_valid = sh_v_q[LAT-1] && (sh_rd_q[LAT-1] != '0);
    assign wb_rd    = sh_rd_q[LAT-1];
    assign wb_src   = sh_src_q[LAT-1];

    always_comb begin
        busy = iss_valid;
        for (int i = 0; i < LAT; i++) begin
            busy = busy | sh_v_q[i];
        end
    end

endmodule

// File: tb/tb_alu_issue_sched.sv
// Randomized and directed bench for alu_issue_sched against a per-cycle history model:
// the ALU sees what was issued LAT cycles ago, busy covers the last LAT+1 issue slots.
module tb_alu_issue_sched;

    localparam int unsigned TAG_W = 5;
    localparam int unsigned LAT   = 2;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned HN    = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [6:0]       req0_opcode, req1_opcode;
    logic [2:0]       req0_funct3, req1_funct3;
    logic [6:0]       req0_funct7, req1_funct7;
    logic [TAG_W-1:0] req0_rd, req1_rd;
    logic             alu_stall;
    logic             iss_valid;
    logic [6:0]       iss_opcode;
    logic [2:0]       iss_funct3;
    logic [6:0]       iss_funct7;
    logic [TAG_W-1:0] iss_rd;
    logic             iss_src;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_rd;
    logic             wb_src;
    logic             ill_op;
    logic             busy;
    logic [CNT_W-1:0] issue_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: what occupied the issue slot in each cycle (ring of HN cycles).
    bit               hv   [HN];
    logic [6:0]       hop  [HN];
    logic [2:0]       hf3  [HN];
    logic [6:0]       hf7  [HN];
    logic [TAG_W-1:0] hrd  [HN];
    bit               hsrc [HN];
    bit               m_rr  = 1'b0;
    bit               m_ill = 1'b0;
    int               m_cnt = 0;
    int               cur   = 16;

    always #5 clk = ~clk;

    alu_issue_sched #(.TAG_W(TAG_W), .LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_funct3(req0_funct3), .req0_funct7(req0_funct7), .req0_rd(req0_rd),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_funct3(req1_funct3), .req1_funct7(req1_funct7), .req1_rd(req1_rd),
        .alu_stall(alu_stall),
        .iss_valid(iss_valid), .iss_opcode(iss_opcode), .iss_funct3(iss_funct3),
        .iss_funct7(iss_funct7), .iss_rd(iss_rd), .iss_src(iss_src),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_src(wb_src),
        .ill_op(ill_op), .busy(busy), .issue_cnt(issue_cnt)
    );

    function automatic bit is_legal(input logic [6:0] op);
        return (op == 7'b0110011) || (op == 7'b0010011);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cur, obs, exp);
        end
    endtask

    // One clock cycle: drive controls at the negedge, check, then advance model at posedge.
    task automatic step(input logic rstn, input logic stall);
        bit g0, g1, legal, exp_busy, wv;
        int w;
        reset     = rstn;
        alu_stall = stall;
        #1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (rstn && !stall) begin
            if (req0_valid && req1_valid) begin
                g0 = !m_rr;
                g1 = m_rr;
            end else begin
                g0 = req0_valid;
                g1 = req1_valid;
            end
        end
        chk("req0_ready", 32'(req0_ready), 32'(g0));
        chk("req1_ready", 32'(req1_ready), 32'(g1));
        chk("iss_valid", 32'(iss_valid), 32'(hv[cur % HN]));
        if (hv[cur % HN]) begin
            chk("iss_opcode", 32'(iss_opcode), 32'(hop[cur % HN]));
            chk("iss_funct3", 32'(iss_funct3), 32'(hf3[cur % HN]));
            chk("iss_funct7", 32'(iss_funct7), 32'(hf7[cur % HN]));
            chk("iss_rd", 32'(iss_rd), 32'(hrd[cur % HN]));
            chk("iss_src", 32'(iss_src), 32'(hsrc[cur % HN]));
        end
        w  = (cur - LAT) % HN;
        wv = hv[w] && (hrd[w] != '0);
        chk("wb_valid", 32'(wb_valid), 32'(wv));
        if (wv) begin
            chk("wb_rd", 32'(wb_rd), 32'(hrd[w]));
            chk("wb_src", 32'(wb_src), 32'(hsrc[w]));
        end
        exp_busy = 1'b0;
        for (int k = 0; k <= LAT; k++) exp_busy |= hv[(cur - k) % HN];
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("ill_op", 32'(ill_op), 32'(m_ill));
        chk("issue_cnt", 32'(issue_cnt), 32'(m_cnt));

        @(posedge clk);
        legal = g1 ? is_legal(req1_opcode) : is_legal(req0_opcode);
        if (!rstn) begin
            for (int k = 0; k < HN; k++) hv[k] = 1'b0;
            m_rr  = 1'b0;
            m_ill = 1'b0;
            m_cnt = 0;
        end else begin
            if (hv[cur % HN] && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            m_ill = (g0 || g1) && !legal;
            if (g0 || g1) m_rr = g0;
            w = (cur + 1) % HN;
            hv[w] = (g0 || g1) && legal;
            hop[w]  = g1 ? req1_opcode : req0_opcode;
            hf3[w]  = g1 ? req1_funct3 : req0_funct3;
            hf7[w]  = g1 ? req1_funct7 : req0_funct7;
            hrd[w]  = g1 ? req1_rd : req0_rd;
            hsrc[w] = g1;
        end
        @(negedge clk);
        cur++;
    endtask

    initial begin
        reset = 1'b0;
        alu_stall = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_opcode = 7'b0110011; req1_opcode = 7'b0010011;
        req0_funct3 = 3'd0; req1_funct3 = 3'd5;
        req0_funct7 = 7'h00; req1_funct7 = 7'h20;
        req0_rd = '0; req1_rd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset held with both requesters valid
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (3) step(1'b0, 1'b0);

        // Contention: grants alternate starting from req0
        for (int i = 0; i < 6; i++) begin
            req0_rd = TAG_W'(i + 1);
            req1_rd = TAG_W'(i + 1);
            step(1'b1, 1'b0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) step(1'b1, 1'b0);
        chk("cnt_after_contention", 32'(issue_cnt), 32'd6);

        // Stall: pointer freezes, pipeline drains
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_rd = 5'd7; req1_rd = 5'd8;
        step(1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) step(1'b1, 1'b0);

        // Illegal opcode on req1
        req1_valid = 1'b1; req1_opcode = 7'b1100011;
        step(1'b1, 1'b0);
        req1_valid = 1'b0; req1_opcode = 7'b0010011;
        repeat (3) step(1'b1, 1'b0);

        // rd = 0 retires silently
        req0_valid = 1'b1; req0_rd = '0;
        step(1'b1, 1'b0);
        req0_valid = 1'b0;
        repeat (3) step(1'b1, 1'b0);

        // Counter saturation with 20 back-to-back issues
        req0_valid = 1'b1; req0_rd = 5'd3;
        repeat (20) step(1'b1, 1'b0);
        req0_valid = 1'b0;
        repeat (3) step(1'b1, 1'b0);
        chk("cnt_saturated", 32'(issue_cnt), 32'd15);

        // Mid-flight reset discards both uops
        req0_valid = 1'b1; req0_rd = 5'd9;
        step(1'b1, 1'b0);
        req0_rd = 5'd10;
        step(1'b1, 1'b0);
        req0_valid = 1'b0;
        step(1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            int sel;
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            req0_opcode = (sel == 0) ? 7'($urandom) : (sel < 5 ? 7'b0110011 : 7'b0010011);
            sel = $urandom_range(0, 9);
            req1_opcode = (sel == 0) ? 7'($urandom) : (sel < 5 ? 7'b0110011 : 7'b0010011);
            req0_funct3 = 3'($urandom); req1_funct3 = 3'($urandom);
            req0_funct7 = 7'($urandom); req1_funct7 = 7'($urandom);
            req0_rd = TAG_W'($urandom_range(0, 7));
            req1_rd = TAG_W'($urandom);
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
